serial_alu_ctrl: RTL and testbench
==================================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 Port: alu_op  input  3  opcode {op2,op1,op0}: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes are illegal.
REQ-006 Port: a  input  WIDTH  operand A; captured on the cycle start is accepted.
REQ-007 Port: b  input  WIDTH  operand B; captured on the cycle start is accepted.
REQ-008 Port: busy  output  1  high from the cycle after acceptance until done has been issued.
REQ-009 Port: done  output  1  one-cycle pulse; result is valid on that cycle.
REQ-010 Port: result  output  WIDTH  final result; held from done until the next accepted start.
REQ-011 Port: carry_out  output  1  carry out of bit WIDTH-1; held with result.
REQ-012 Port: illegal_op  output  1  one-cycle pulse when start is high in IDLE with an illegal opcode.

Function
REQ-013 The block SHALL compute bit-serially, using one internal 1-bit ALU slice (inputs ai, bi, ci, less_i, op2..op0; outputs ri, c_next) once per cycle, LSB first.
REQ-014 FSM states SHALL be IDLE, RUN and FINISH; reset enters IDLE.
REQ-015 IDLE with start=1 and a legal opcode: latch a, b and alu_op, load the carry register with op2, clear the bit counter, and go to RUN.
REQ-016 IDLE with start=1 and an illegal opcode: pulse illegal_op, stay in IDLE, and leave result unchanged.
REQ-017 RUN SHALL process bit k on its k-th cycle (k = 0..WIDTH-1): drive ai=a[k], bi=b[k], ci=carry register, and less_i=0; write ri into result bit k; load c_next into the carry register.
REQ-018 For SLT, ri from every bit SHALL be discarded in RUN, and result[WIDTH-1:1] SHALL be 0.
REQ-019 When the counter reaches WIDTH-1, after that bit is processed, the FSM SHALL go to FINISH.
REQ-020 FINISH, for SLT: result[0] = sum bit WIDTH-1 of a + ~b + 1, captured during the last RUN cycle; no overflow correction is applied.
REQ-021 FINISH SHALL assert done for exactly one cycle, latch carry_out from the carry register, and return to IDLE.
REQ-022 Latency: start accepted at edge N gives done high in the cycle after edge N+WIDTH+1 (WIDTH RUN cycles plus one FINISH cycle).
REQ-023 start while busy SHALL be ignored, with no queueing and no effect on the operation in flight.
REQ-024 start SHALL be accepted in the IDLE cycle that immediately follows FINISH, giving back-to-back operations with no bubble beyond FINISH.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-026 carry_out SHALL equal bit WIDTH of a+b for ADD and of a+~b+1 for SUB/SLT; for AND/OR it SHALL equal the slice's c_next at the last bit.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and clear the counter, carry register, result, carry_out, busy, done and illegal_op to 0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; operation resumes only after a new start following reset release.

Configuration
REQ-029 Macro SERIAL_ALU_ZERO_FLAG_EN defined: add output port zero (1 bit), equal to 1 when result == 0, updated in FINISH, held with result, and reset to 0.
REQ-030 Macro SERIAL_ALU_ZERO_FLAG_EN undefined: port zero and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 ADD, WIDTH=32: a=0xFFFFFFFF, b=0x00000001 -> done on cycle 33 after acceptance, result=0x00000000, carry_out=1, zero=1 when enabled.
REQ-032 SUB then SLT back-to-back: a=5, b=7 -> SUB result=0xFFFFFFFE, carry_out=0; SLT started on the cycle after done -> result=0x00000001.
REQ-033 AND/OR: a=0xF0F0A5A5, b=0x0FF0FF00 -> AND result=0x00F0A500; OR result=0xFFF0FFA5.
REQ-034 start pulsed at RUN cycle 10 with a different opcode and operands -> first operation's result unchanged, single done, second request dropped.
REQ-035 rst_n pulsed low at RUN cycle 20 -> all outputs 0 at once, no done; new ADD 3+4 after release -> result=7.
REQ-036 Illegal opcode 011 with start in IDLE -> illegal_op high for one cycle, busy stays 0, prior result retained.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one 1-bit slice is reused LSB first over WIDTH cycles.
// Optional zero flag output enabled by defining SERIAL_ALU_ZERO_FLAG_EN.
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             illegal_op
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  // state  | meaning
  // IDLE   | waiting for start; operands latched on acceptance
  // RUN    | one bit per cycle through the slice, LSB first
  // FINISH | finalise SLT bit, latch carry_out, pulse done
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [2:0]     OP_SLT = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             slt_q, slt_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic ai, bi, ci, less_i, bi_eff, sum, ri, c_next;
  logic op_legal;

  always_comb begin
    unique case (alu_op)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  // 1-bit ALU slice; op2 inverts b and seeds the carry for subtraction
  always_comb begin
    ai     = a_q[cnt_q];
    bi     = b_q[cnt_q];
    ci     = carry_q;
    less_i = 1'b0;
    bi_eff = bi ^ op_q[2];
    sum    = ai ^ bi_eff ^ ci;
    c_next = (ai & bi_eff) | (ci & (ai ^ bi_eff));
    unique case (op_q[1:0])
      2'b00:   ri = ai & bi_eff;
      2'b01:   ri = ai | bi_eff;
      2'b10:   ri = sum;
      default: ri = less_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    slt_d       = slt_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op_legal) begin
            a_d     = a;
            b_d     = b;
            op_d    = alu_op;
            carry_d = alu_op[2];
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      RUN: begin
        result_d[cnt_q] = (op_q == OP_SLT) ? 1'b0 : ri;
        carry_d         = c_next;
        if (cnt_q == LAST) begin
          slt_d   = sum;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        if (op_q == OP_SLT) begin
          result_d    = '0;
          result_d[0] = slt_q;
        end
        carry_out_d = carry_q;
        done_d      = 1'b1;
        state_d     = IDLE;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        zero_d      = ~|result_d;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      slt_q       <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      slt_q       <= slt_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign carry_out  = carry_out_q;
  assign illegal_op = illegal_q;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  assign zero       = zero_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl (WIDTH=32) with directed vectors.
module tb_serial_alu_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    alu_op = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, carry_out, illegal_op;
  logic [W-1:0]  result;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic          zero;
`endif

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .illegal_op(illegal_op)
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("carry_out", {63'd0, carry_out}, {63'd0, e.cy});
        check("done latency", 64'(cyc), 64'(e.cyc));
        check("busy at done", {63'd0, busy}, 64'd0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
        check("zero", {63'd0, zero}, {63'd0, (e.res == '0)});
`endif
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic ec);
    exp_t e;
    start = 1'b1; alu_op = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    e.res = er; e.cy = ec; e.cyc = cyc + W + 1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 60 && done !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    check({name, " done reached"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset result", {32'd0, result}, 64'd0);
    check("reset carry", {63'd0, carry_out}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset illegal", {63'd0, illegal_op}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    check("busy in run", {63'd0, busy}, 64'd1);
    wait_done("add wrap");
    issue(3'b010, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0);
    wait_done("add");
    issue(3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_done("sub");
    issue(3'b111, 32'd5, 32'd7, 32'h0000_0001, 1'b0);
    wait_done("slt 5<7");
    issue(3'b000, 32'hF0F0_A5A5, 32'h0FF0_FF00, 32'h00F0_A500, 1'b1);
    wait_done("and");
    issue(3'b001, 32'hF0F0_A5A5, 32'h0FF0_FF00, 32'hFFF0_FFA5, 1'b1);
    wait_done("or");
    issue(3'b111, 32'd7, 32'd5, 32'h0000_0000, 1'b1);
    wait_done("slt 7<5");
    issue(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1'b1);
    wait_done("slt -1<1");
    issue(3'b111, 32'h8000_0000, 32'd1, 32'h0000_0000, 1'b1);
    wait_done("slt overflow");

    // start pulsed mid-operation must be dropped
    @(negedge clk);
    issue(3'b010, 32'd3, 32'd4, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; alu_op = 3'b110; a = 32'd100; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored start");
    repeat (W + 5) @(posedge clk);
    check("no queued op", {63'd0, busy}, 64'd0);

    // reset mid-operation aborts with no done
    @(negedge clk);
    issue(3'b010, 32'd1, 32'd2, 32'd3, 1'b0);
    void'(sb.pop_back());
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort result", {32'd0, result}, 64'd0);
    check("abort carry", {63'd0, carry_out}, 64'd0);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (W + 5) @(posedge clk);
    #1 check("idle after abort", {63'd0, busy}, 64'd0);
    issue(3'b010, 32'd3, 32'd4, 32'd7, 1'b0);
    wait_done("add after reset");

    // illegal opcode in IDLE
    @(negedge clk);
    start = 1'b1; alu_op = 3'b011; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal pulse", {63'd0, illegal_op}, 64'd1);
    check("illegal busy", {63'd0, busy}, 64'd0);
    check("illegal result kept", {32'd0, result}, 64'd7);
    @(posedge clk); #1;
    check("illegal one cycle", {63'd0, illegal_op}, 64'd0);
    check("illegal busy later", {63'd0, busy}, 64'd0);
    check("illegal result later", {32'd0, result}, 64'd7);

    repeat (5) @(posedge clk);
    #1 check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
